mul_limb_serial: RTL
====================

Name: mul_limb_serial

Overview:
- Sequential limb-serial multiplier; successor to the fixed 2x16-bit combinational vector-multiply candidates.
- Multiplies two NLIMB*W-bit operands, presented as packed limbs, into a 2*NLIMB*W-bit product.
- Uses one W x W partial product per clock, with a ready/valid handshake on input and output.
- Sits between the operand staging logic and the result collector in the vector datapath.

Parameters:
W, 16, limb width in bits (>=2)
NLIMB, 2, limbs per operand (>=1); product has 2*NLIMB limbs

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operands a/b valid
in_ready  out  1  block can accept operands
a  in  NLIMB*W  operand A, limb k = a[k*W +: W] (limb 0 least significant)
b  in  NLIMB*W  operand B, same packing
out_valid  out  1  product y valid
out_ready  in  1  consumer accepts y
y  out  2*NLIMB*W  product, limb k = y[k*W +: W]
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset and state set:
  - Reset (one clk edge with rst=1) forces state IDLE, accumulator=0, i=j=0, out_valid=0, busy=0.
  - in_ready=1 in IDLE. y=0 after reset.
  - States: IDLE, MAC, FIX (only with the optional feature), DONE.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1: latch a,b into operand registers, clear accumulator, set i=j=0, go to MAC.
  - in_ready is 0 in every other state. Inputs presented there are ignored.
- MAC: each edge performs acc += (A[i]*B[j]) << (W*(i+j)).
  - Full 2*NLIMB*W-bit add; the unsigned result cannot overflow.
  - j is the inner counter, 0..NLIMB-1. On j wrap, i increments.
  - After the edge processing i=j=NLIMB-1, go to DONE (or FIX when the feature is enabled).
  - MAC occupies exactly NLIMB*NLIMB edges.
- Latency: out_valid rises NLIMB*NLIMB edges after the accepting edge (+1 with the feature). Defaults give 4 (5).
- DONE:
  - out_valid=1, y=acc.
  - On edge with out_ready=1: go to IDLE, out_valid=0.
  - While out_ready=0: hold state; y and out_valid are stable.
- In IDLE after a handoff, y keeps the last product until the next accept clears acc. y is only meaningful while out_valid=1.
- No new operand is accepted in the same edge that retires a result. Minimum issue interval is NLIMB*NLIMB+2 edges (+1 with the feature).
- rst asserted mid-MAC, mid-FIX or in DONE aborts the operation with no output. The pending result is lost and out_valid=0 on the next cycle.
- Operand registers are written only on the accepting edge. Changing a/b after acceptance has no effect.
- NLIMB=1 degenerates to 1 MAC edge. This must work.

Optional Feature:
- Macro: MUL_LIMB_SIGNED_EN.
- Defined: a and b are two's complement; y is the signed 2*NLIMB*W-bit product.
  - MAC is unchanged (unsigned limbs).
  - A single FIX edge then subtracts (A<<N if B msb=1) plus (B<<N if A msb=1) from acc, modulo 2^(2N), where N=NLIMB*W.
  - Then go to DONE. Latency +1.
- Undefined: operands unsigned, no FIX state in the enum or logic, latency NLIMB*NLIMB.

Decomposition:
- Package mul_limb_pkg:
  - state enum (IDLE, MAC, FIX, DONE, 2-bit)
  - default constants W_DEF=16, NLIMB_DEF=2
  - function for the counter width, $clog2 of NLIMB (min 1)
- Sub-module mul_limb_pe:
  - purely combinational W x W unsigned multiplier, 2W-bit output
  - instantiated once
  - isolates the multiplier for later replacement by evolved/optimised netlists

Test Plan:
- Default params, a=0x0001_0002, b=0x0003_0004, out_ready=1 -> out_valid exactly 4 edges after accept, y=0x0000_0003_000A_0008, in_ready returns 1 one edge after handoff.
- a=b=0xFFFF_FFFF -> y=0xFFFF_FFFE_0000_0001; all-zero operands -> y=0.
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid/a/b -> y and out_valid stable, no new accept; then out_ready=1 -> IDLE.
- Assert rst for one edge at the 2nd MAC cycle -> out_valid stays 0, busy=0, in_ready=1 next cycle. Next operation (a=3, b=5) yields y=15.
- W=8, NLIMB=4, random 1000 operand pairs with random out_ready backpressure -> y matches the reference product. Latency is 16 edges.
- MUL_LIMB_SIGNED_EN defined, defaults:
  - a=b=0xFFFF_FFFF -> y=0x0000_0000_0000_0001
  - a=0xFFFF_FFFE, b=3 -> y=0xFFFF_FFFF_FFFF_FFFA
  - latency 5 edges

Source files
------------

// File: rtl/mul_limb_serial_pkg.sv
// ---------------------------------------------------------------------------
// mul_limb_pkg
// Shared types and constants for the limb-serial multiplier.
//   state_t       : FSM encoding (IDLE, MAC, [FIX], DONE), 2 bits
//   W_DEF         : default limb width
//   NLIMB_DEF     : default limbs per operand
//   cnt_width()   : width of the limb counters, $clog2(n) but at least 1
// Configuration macro: MUL_LIMB_SIGNED_EN adds the FIX state used for the
// two's complement correction.
// ---------------------------------------------------------------------------
package mul_limb_pkg;

    localparam int W_DEF     = 16;
    localparam int NLIMB_DEF = 2;

`ifdef MUL_LIMB_SIGNED_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd3
    } state_t;
`endif

    // A single-limb operand still needs a 1-bit counter so the selects stay legal.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_limb_serial_pe.sv
// ---------------------------------------------------------------------------
// mul_limb_pe
// Purely combinational W x W unsigned multiplier producing a 2W-bit result.
// Kept as its own module so the multiplier can be swapped for an optimised
// netlist without touching the sequencing logic.
//   op_a : W-bit unsigned limb
//   op_b : W-bit unsigned limb
//   prod : 2W-bit unsigned product
// ---------------------------------------------------------------------------
module mul_limb_pe #(
    parameter int W = 16
) (
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic [2*W-1:0] prod
);

    // Zero-extend both sides so the multiply is evaluated at full 2W width.
    assign prod = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};

endmodule

// File: rtl/mul_limb_serial.sv
// ---------------------------------------------------------------------------
// mul_limb_serial
// Sequential limb-serial multiplier: one W x W partial product per clock,
// accumulated into a 2*NLIMB*W-bit product.
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operands a/b valid
//   in_ready   : high only in IDLE, block can accept operands
//   a, b       : NLIMB*W-bit operands, limb k = [k*W +: W]
//   out_valid  : product y valid (DONE state)
//   out_ready  : consumer accepts y
//   y          : 2*NLIMB*W-bit product, holds last product until next accept
//   busy       : high in any state other than IDLE
// Configuration macro: MUL_LIMB_SIGNED_EN treats a/b as two's complement and
// adds one FIX cycle after the unsigned accumulation.
// ---------------------------------------------------------------------------
module mul_limb_serial
    import mul_limb_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int NLIMB = NLIMB_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NLIMB*W-1:0]     a,
    input  logic [NLIMB*W-1:0]     b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*NLIMB*W-1:0]   y,
    output logic                   busy
);

    localparam int N  = NLIMB * W;
    localparam int CW = cnt_width(NLIMB);
    localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

    state_t          state;
    state_t          state_d;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [2*N-1:0]  acc;
    logic [CW-1:0]   i_q;
    logic [CW-1:0]   j_q;
    logic [W-1:0]    limb_a;
    logic [W-1:0]    limb_b;
    logic [2*W-1:0]  pp;
    logic [2*N-1:0]  pp_ext;
    logic [2*N-1:0]  pp_sh;
    logic            accept;
    logic            mac_en;
    logic            last_step;
`ifdef MUL_LIMB_SIGNED_EN
    logic            fix_en;
    logic [2*N-1:0]  fix_sub;
`endif

    assign limb_a    = a_q[int'(i_q)*W +: W];
    assign limb_b    = b_q[int'(j_q)*W +: W];
    assign last_step = (i_q == LAST) && (j_q == LAST);

    mul_limb_pe #(.W(W)) u_pe (
        .op_a (limb_a),
        .op_b (limb_b),
        .prod (pp)
    );

    // Align the partial product to limb position i+j of the result.
    always_comb begin
        pp_ext          = '0;
        pp_ext[2*W-1:0] = pp;
        pp_sh           = pp_ext << (W * (int'(i_q) + int'(j_q)));
    end

`ifdef MUL_LIMB_SIGNED_EN
    // Two's complement correction of an unsigned product: a negative operand
    // contributed an extra 2^N times the other operand, remove it modulo 2^2N.
    always_comb begin
        fix_sub = '0;
        if (b_q[N-1]) fix_sub = fix_sub + {a_q, {N{1'b0}}};
        if (a_q[N-1]) fix_sub = fix_sub + {b_q, {N{1'b0}}};
    end
`endif

    // Next-state and step enables.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        mac_en  = 1'b0;
`ifdef MUL_LIMB_SIGNED_EN
        fix_en  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_step) begin
`ifdef MUL_LIMB_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef MUL_LIMB_SIGNED_EN
            FIX: begin
                fix_en  = 1'b1;
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operands, accumulator and limb counters (j inner, i outer).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            i_q   <= '0;
            j_q   <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                a_q <= a;
                b_q <= b;
                acc <= '0;
                i_q <= '0;
                j_q <= '0;
            end else if (mac_en) begin
                acc <= acc + pp_sh;
                if (j_q == LAST) begin
                    j_q <= '0;
                    i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end
`ifdef MUL_LIMB_SIGNED_EN
            else if (fix_en) begin
                acc <= acc - fix_sub;
            end
`endif
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign y         = acc;

endmodule
